// File: rtl/vec_sum_seq_if.sv
// Chunk input stream and packet result stream of vec_sum_seq.
// o_sum_sat exists only when VEC_SUM_SAT_EN is defined.
interface vec_sum_seq_if #(
  parameter int bit_width = 8,
  parameter int length    = 32,
  parameter int acc_width = 16,
  parameter int max_beats = 256
);
  localparam int beats_w = $clog2(max_beats) + 1;

  logic signed [bit_width-1:0] i_vec [length];
  logic                        i_vec_valid;
  logic                        i_vec_last;
  logic                        o_vec_ready;
  logic signed [acc_width-1:0] o_sum;
  logic [beats_w-1:0]          o_sum_beats;
  logic                        o_sum_trunc;
  logic                        o_sum_valid;
  logic                        i_sum_ready;
`ifdef VEC_SUM_SAT_EN
  logic                        o_sum_sat;
`endif

  modport slave (
    input  i_vec, i_vec_valid, i_vec_last, i_sum_ready,
    output o_vec_ready, o_sum, o_sum_beats, o_sum_trunc, o_sum_valid
`ifdef VEC_SUM_SAT_EN
    , output o_sum_sat
`endif
  );

  modport master (
    output i_vec, i_vec_valid, i_vec_last, i_sum_ready,
    input  o_vec_ready, o_sum, o_sum_beats, o_sum_trunc, o_sum_valid
`ifdef VEC_SUM_SAT_EN
    , input o_sum_sat
`endif
  );
endinterface

// File: rtl/vec_sum_seq.sv
// Streams signed chunks through a length-wide adder tree and accumulates one sum per packet.
// Define VEC_SUM_SAT_EN for saturating accumulation and the o_sum_sat flag.
module vec_sum_seq #(
  parameter int bit_width = 8,
  parameter int length    = 32,
  parameter int acc_width = 16,
  parameter int max_beats = 256
) (
  input  logic         i_clk,
  input  logic         i_rst,
  vec_sum_seq_if.slave bus
);
  localparam int TREE_W  = bit_width + $clog2(length);
  localparam int BEATS_W = $clog2(max_beats) + 1;
  localparam logic [BEATS_W-1:0] MAX_BEATS = BEATS_W'(max_beats);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_e;

  state_e                      state_q, state_d;
  logic signed [acc_width-1:0] acc_q, acc_d;
  logic [BEATS_W-1:0]          beats_q, beats_d;
  logic                        trunc_q, trunc_d;

  logic signed [TREE_W-1:0]    tree_sum;
  logic signed [acc_width-1:0] tree_ext, acc_base, acc_next;
  logic [BEATS_W-1:0]          beats_next;
  logic                        accept, first_beat, end_pkt;

  always_comb begin
    // NOTE: blocking assignments here: each iteration must see the partial sum of the previous one.
    tree_sum = '0;
    for (int i = 0; i < length; i++) begin
      tree_sum += TREE_W'(bus.i_vec[i]);
    end
  end

  assign tree_ext   = acc_width'(tree_sum);
  assign accept     = bus.i_vec_valid && bus.o_vec_ready;
  // Any accepted beat outside ACC opens a new packet, including the one overlapping a release.
  assign first_beat = (state_q != S_ACC);
  assign acc_base   = first_beat ? '0 : acc_q;
  assign beats_next = first_beat ? BEATS_W'(1) : beats_q + BEATS_W'(1);
  assign end_pkt    = bus.i_vec_last || (beats_next == MAX_BEATS);

`ifdef VEC_SUM_SAT_EN
  localparam logic signed [acc_width-1:0] ACC_MAX = {1'b0, {(acc_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] ACC_MIN = {1'b1, {(acc_width-1){1'b0}}};

  logic signed [acc_width:0] acc_wide;
  logic                      clamp;
  logic                      sat_q, sat_d;

  always_comb begin
    acc_wide = (acc_width+1)'(acc_base) + (acc_width+1)'(tree_ext);
    clamp    = acc_wide[acc_width] != acc_wide[acc_width-1];
    if (!clamp)                acc_next = acc_wide[acc_width-1:0];
    else if (acc_wide[acc_width]) acc_next = ACC_MIN;
    else                       acc_next = ACC_MAX;
  end
`else
  assign acc_next = acc_base + tree_ext;
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    beats_d = beats_q;
    trunc_d = trunc_q;
`ifdef VEC_SUM_SAT_EN
    sat_d   = sat_q;
`endif
    if (accept) begin
      acc_d   = acc_next;
      beats_d = beats_next;
      trunc_d = end_pkt && !bus.i_vec_last;
`ifdef VEC_SUM_SAT_EN
      sat_d   = (first_beat ? 1'b0 : sat_q) | clamp;
`endif
      state_d = end_pkt ? S_OUT : S_ACC;
    end else if (state_q == S_OUT && bus.i_sum_ready) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      beats_q <= '0;
      trunc_q <= 1'b0;
`ifdef VEC_SUM_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      beats_q <= beats_d;
      trunc_q <= trunc_d;
`ifdef VEC_SUM_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign bus.o_vec_ready = (state_q != S_OUT) || bus.i_sum_ready;
  assign bus.o_sum       = acc_q;
  assign bus.o_sum_beats = beats_q;
  assign bus.o_sum_trunc = trunc_q;
  assign bus.o_sum_valid = (state_q == S_OUT);
`ifdef VEC_SUM_SAT_EN
  assign bus.o_sum_sat   = sat_q;
`endif
endmodule

// File: tb/tb_vec_sum_seq.sv
// Bench for vec_sum_seq: a packet-level arithmetic model feeds expected-result queues,
// one compare process checks both instances each cycle, directed tests pin literal values.
`timescale 1ns/1ps
module tb_vec_sum_seq;
  localparam int BW     = 8;
  localparam int LEN    = 32;
  localparam int ACC_W  = 16;
  localparam int MAXB_A = 256;
  localparam int MAXB_B = 4;

  typedef struct {
    int sum;
    int beats;
    bit trunc;
    bit sat;
  } result_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vec_sum_seq_if #(.bit_width(BW), .length(LEN), .acc_width(ACC_W), .max_beats(MAXB_A)) bus_a ();
  vec_sum_seq_if #(.bit_width(BW), .length(LEN), .acc_width(ACC_W), .max_beats(MAXB_B)) bus_b ();

  vec_sum_seq #(.bit_width(BW), .length(LEN), .acc_width(ACC_W), .max_beats(MAXB_A)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a));
  vec_sum_seq #(.bit_width(BW), .length(LEN), .acc_width(ACC_W), .max_beats(MAXB_B)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b));

  int      n_vec = 0;
  int      n_err = 0;
  bit      cmp_en = 1'b0;
  result_t exp_a[$];
  result_t exp_b[$];
  int      m_acc   [2];
  int      m_beats [2];
  bit      m_sat   [2];
  bit      m_open  [2];
  int      elems   [LEN];
  int      wait_cycles;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int wrap(input int v);
    int m = v & ((1 << ACC_W) - 1);
    if (m >= (1 << (ACC_W - 1))) m -= (1 << ACC_W);
    return m;
  endfunction

  // Packet model: plain integer running sum, closed by last or by the beat limit.
  task automatic model_beat(input int which, input int tsum, input bit last);
    result_t r;
    int maxb = (which == 0) ? MAXB_A : MAXB_B;
    if (!m_open[which]) begin
      m_acc[which]   = 0;
      m_beats[which] = 0;
      m_sat[which]   = 1'b0;
      m_open[which]  = 1'b1;
    end
    m_acc[which] += tsum;
    m_beats[which]++;
`ifdef VEC_SUM_SAT_EN
    begin
      int hi = (1 << (ACC_W - 1)) - 1;
      int lo = -(1 << (ACC_W - 1));
      if (m_acc[which] > hi) begin m_acc[which] = hi; m_sat[which] = 1'b1; end
      else if (m_acc[which] < lo) begin m_acc[which] = lo; m_sat[which] = 1'b1; end
    end
`else
    m_acc[which] = wrap(m_acc[which]);
`endif
    if (last || m_beats[which] == maxb) begin
      r.sum   = m_acc[which];
      r.beats = m_beats[which];
      r.trunc = !last;
      r.sat   = m_sat[which];
      if (which == 0) exp_a.push_back(r);
      else            exp_b.push_back(r);
      m_open[which] = 1'b0;
    end
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < LEN; i++) elems[i] = v;
  endtask

  task automatic drive(input int which, input bit valid, input bit last);
    if (which == 0) begin
      bus_a.i_vec_valid = valid;
      bus_a.i_vec_last  = last;
      for (int i = 0; i < LEN; i++) bus_a.i_vec[i] = BW'(elems[i]);
    end else begin
      bus_b.i_vec_valid = valid;
      bus_b.i_vec_last  = last;
      for (int i = 0; i < LEN; i++) bus_b.i_vec[i] = BW'(elems[i]);
    end
  endtask

  // Presents one beat and returns one time step after the edge that accepted it.
  task automatic send_beat(input int which, input bit last);
    bit acc = 1'b0;
    int tsum = 0;
    for (int i = 0; i < LEN; i++) tsum += elems[i];
    drive(which, 1'b1, last);
    wait_cycles = 0;
    while (!acc && wait_cycles < 50) begin
      @(negedge clk);
      acc = (which == 0) ? bus_a.o_vec_ready : bus_b.o_vec_ready;
      @(posedge clk);
      #1;
      wait_cycles++;
    end
    drive(which, 1'b0, 1'b0);
    if (acc) model_beat(which, tsum, last);
    else     check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int which, input int n, input bit last);
    drive(which, 1'b0, last);
    repeat (n) @(posedge clk);
    #1;
    drive(which, 1'b0, 1'b0);
  endtask

  task automatic expect_lit(input string name, input int which, input int sum, input int beats,
                            input bit trunc);
    if (which == 0) begin
      check({name, "_valid"}, bus_a.o_sum_valid, 1);
      check({name, "_sum"},   bus_a.o_sum, sum);
      check({name, "_beats"}, bus_a.o_sum_beats, beats);
      check({name, "_trunc"}, bus_a.o_sum_trunc, trunc);
    end else begin
      check({name, "_valid"}, bus_b.o_sum_valid, 1);
      check({name, "_sum"},   bus_b.o_sum, sum);
      check({name, "_beats"}, bus_b.o_sum_beats, beats);
      check({name, "_trunc"}, bus_b.o_sum_trunc, trunc);
    end
  endtask

  task automatic cmp_stream(input int which);
    logic v, rdy, srdy, tr, st;
    logic signed [ACC_W-1:0] s;
    int b;
    bit empty;
    result_t e;
    string p = (which == 0) ? "a" : "b";
    st = 1'b0;
    if (which == 0) begin
      v = bus_a.o_sum_valid; rdy = bus_a.o_vec_ready; srdy = bus_a.i_sum_ready;
      s = bus_a.o_sum; b = int'(bus_a.o_sum_beats); tr = bus_a.o_sum_trunc;
`ifdef VEC_SUM_SAT_EN
      st = bus_a.o_sum_sat;
`endif
      empty = (exp_a.size() == 0);
    end else begin
      v = bus_b.o_sum_valid; rdy = bus_b.o_vec_ready; srdy = bus_b.i_sum_ready;
      s = bus_b.o_sum; b = int'(bus_b.o_sum_beats); tr = bus_b.o_sum_trunc;
`ifdef VEC_SUM_SAT_EN
      st = bus_b.o_sum_sat;
`endif
      empty = (exp_b.size() == 0);
    end
    check({p, "_ready_rule"}, rdy, !v || srdy);
    if (v) begin
      if (empty) begin
        check({p, "_unexpected_result"}, 1, 0);
      end else begin
        e = (which == 0) ? exp_a[0] : exp_b[0];
        check({p, "_sum"},   s, e.sum);
        check({p, "_beats"}, b, e.beats);
        check({p, "_trunc"}, tr, e.trunc);
`ifdef VEC_SUM_SAT_EN
        check({p, "_sat"},   st, e.sat);
`endif
        if (srdy) begin
          if (which == 0) void'(exp_a.pop_front());
          else            void'(exp_b.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      cmp_stream(0);
      cmp_stream(1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    set_all(0);
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    bus_a.i_sum_ready = 1'b1;
    bus_b.i_sum_ready = 1'b1;
    m_open[0] = 1'b0;
    m_open[1] = 1'b0;

    // Reset values.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid",  bus_a.o_sum_valid, 0);
    check("rst_sum",    bus_a.o_sum, 0);
    check("rst_beats",  bus_a.o_sum_beats, 0);
    check("rst_trunc",  bus_a.o_sum_trunc, 0);
    check("rst_ready",  bus_a.o_vec_ready, 1);
    check("rst_b_valid", bus_b.o_sum_valid, 0);
    check("rst_b_ready", bus_b.o_vec_ready, 1);
    cmp_en = 1'b1;

    // Single beat of ones: result on the next cycle.
    set_all(1);
    send_beat(0, 1'b1);
    expect_lit("single", 0, 32, 1, 1'b0);
    idle(0, 2, 1'b0);

    // Four beats of -1 with valid gaps.
    set_all(-1);
    for (int k = 1; k <= 4; k++) begin
      send_beat(0, k == 4);
      if (k != 4) idle(0, 1, 1'b0);
    end
    expect_lit("neg4", 0, -128, 4, 1'b0);
    idle(0, 2, 1'b0);

    // Backpressure, then release overlapping the next packet's first beat.
    bus_a.i_sum_ready = 1'b0;
    set_all(3);
    send_beat(0, 1'b1);
    expect_lit("bp", 0, 96, 1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready_low", bus_a.o_vec_ready, 0);
      check("bp_sum_hold",  bus_a.o_sum, 96);
      check("bp_beats_hold", bus_a.o_sum_beats, 1);
    end
    @(posedge clk);
    #1;
    bus_a.i_sum_ready = 1'b1;
    set_all(2);
    send_beat(0, 1'b0);
    check("bp_no_bubble_wait", wait_cycles, 1);
    check("bp_new_pkt_open", bus_a.o_sum_valid, 0);
    set_all(-5);
    send_beat(0, 1'b1);
    expect_lit("bp_next", 0, -96, 2, 1'b0);
    idle(0, 2, 1'b0);

    // Forced termination at four beats on the short instance.
    set_all(1);
    for (int k = 1; k <= 6; k++) begin
      send_beat(1, k == 6);
      if (k == 4) expect_lit("trunc1", 1, 128, 4, 1'b1);
      if (k == 5) check("trunc_no_bubble", wait_cycles, 1);
    end
    expect_lit("trunc2", 1, 64, 2, 1'b0);
    idle(1, 2, 1'b0);

    // Reset in the middle of a packet discards it.
    set_all(1);
    send_beat(0, 1'b0);
    send_beat(0, 1'b0);
    drive(0, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0);
    m_open[0] = 1'b0;
    m_open[1] = 1'b0;
    check("midrst_valid", bus_a.o_sum_valid, 0);
    check("midrst_ready", bus_a.o_vec_ready, 1);
    set_all(2);
    send_beat(0, 1'b1);
    expect_lit("after_rst", 0, 64, 1, 1'b0);
    idle(0, 2, 1'b0);

    // Nine beats of 127 overflow a 16-bit accumulator.
    set_all(127);
    for (int k = 1; k <= 9; k++) send_beat(0, k == 9);
`ifdef VEC_SUM_SAT_EN
    expect_lit("ovf", 0, 32767, 9, 1'b0);
    check("ovf_sat_flag", bus_a.o_sum_sat, 1);
`else
    expect_lit("ovf", 0, -28960, 9, 1'b0);
`endif
    idle(0, 2, 1'b0);

    // Mixed element values and sign extension of -128, back to back.
    for (int i = 0; i < LEN; i++) elems[i] = i;
    send_beat(0, 1'b0);
    set_all(-128);
    send_beat(0, 1'b1);
    check("mixed_throughput", wait_cycles, 1);
    expect_lit("mixed", 0, -3600, 2, 1'b0);

    // Consecutive single-beat packets at one beat per cycle.
    set_all(4);
    send_beat(0, 1'b1);
    set_all(-1);
    send_beat(0, 1'b1);
    check("b2b_wait", wait_cycles, 1);
    expect_lit("b2b", 0, -32, 1, 1'b0);
    idle(0, 2, 1'b0);

    // Last without valid is ignored.
    set_all(1);
    send_beat(0, 1'b0);
    idle(0, 2, 1'b1);
    check("last_novalid_open", bus_a.o_sum_valid, 0);
    send_beat(0, 1'b1);
    expect_lit("last_novalid", 0, 64, 2, 1'b0);

    idle(0, 4, 1'b0);
    check("a_results_drained", exp_a.size(), 0);
    check("b_results_drained", exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vec_sum_seq.md
Name: vec_sum_seq

Overview:
- Sequencer that streams an arbitrarily long signed int vector through a `length`-wide adder tree, one chunk per beat.
- Accumulates per-chunk tree sums into a running total; emits one result per packet (sequence of beats terminated by `i_vec_last`).
- Sits between the MX block unpacker (upstream) and the scale/normalise stage (downstream).
- Valid/ready handshakes on both sides.

Parameters:
- bit_width, 8, width of each signed two's-complement element.
- length, 32, elements per beat; power of two, >= 2.
- acc_width, 16, accumulator/result width; must be >= bit_width+$clog2(length).
- max_beats, 256, maximum beats per packet before forced termination.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_vec  input  bit_width x length (unpacked array [length])  chunk elements, signed.
- i_vec_valid  input  1  chunk valid.
- i_vec_last  input  1  chunk is final beat of packet; qualified by i_vec_valid.
- o_vec_ready  output  1  block can accept a chunk.
- o_sum  output  acc_width  packet sum, signed.
- o_sum_beats  output  $clog2(max_beats)+1  number of beats summed into o_sum.
- o_sum_trunc  output  1  packet forcibly terminated at max_beats.
- o_sum_valid  output  1  result valid.
- i_sum_ready  input  1  downstream accepts result.

Behaviour:
- Reset: synchronous, active-high; i_rst high on a rising edge of i_clk resets the block.
- Tree sum: signed sum of the `length` elements, each sign-extended; width bit_width+$clog2(length); combinational within the cycle.
  - Sign-extended to acc_width before accumulation.
- States: IDLE (next beat is first), ACC (mid-packet), OUT (result held).
- o_vec_ready = (state != OUT) || i_sum_ready. Combinational from state and i_sum_ready; no dependence on i_vec_valid.
- Accept = i_vec_valid && o_vec_ready. Release = o_sum_valid && i_sum_ready.
- IDLE + accept:
  - acc <= tree_sum; beats <= 1.
  - Go OUT if i_vec_last, else ACC.
- ACC + accept:
  - acc <= acc + tree_sum; beats <= beats+1.
  - Go OUT if i_vec_last or beats+1 == max_beats.
  - Set trunc when max_beats is reached without i_vec_last.
- ACC without accept: hold all state; gaps in i_vec_valid are allowed.
- OUT:
  - o_sum_valid=1; o_sum, o_sum_beats, o_sum_trunc driven from registers and held stable until release.
  - Release without accept: go IDLE.
  - Release with accept in the same cycle: treat as IDLE + accept (new packet starts, no bubble); trunc cleared.
- Latency: last beat accepted in cycle t -> o_sum_valid=1 in cycle t+1. Sustained throughput of 1 beat/cycle with i_sum_ready held high.
- Truncation: the beat after a forced termination is the first beat of a new packet. The downstream source is responsible for any realignment.
- Overflow without the optional feature: accumulator wraps modulo 2^acc_width.
- Reset values: state=IDLE, acc=0, beats=0, trunc=0, o_sum_valid=0, o_sum=0, o_sum_beats=0, o_sum_trunc=0. o_vec_ready=1 in the first cycle after reset.
- Reset mid-packet or during OUT: partial sum and held result are discarded; no output produced.
- i_vec_last with i_vec_valid low: ignored.

Optional Feature:
- Macro: VEC_SUM_SAT_EN.
- Defined:
  - Each accumulate step saturates to [-2^(acc_width-1), 2^(acc_width-1)-1].
  - Once saturated, the sum is still further accumulated from the clamped value.
  - Adds output o_sum_sat (1 bit) = a clamp occurred in the packet. Registered with the result; reset 0; cleared on a new first beat.
- Undefined: wrap-around arithmetic; port o_sum_sat absent.

Test Plan:
- Single beat, all elements 1, last=1 -> next cycle o_sum=32, o_sum_beats=1, o_sum_trunc=0, o_sum_valid=1.
- 4 beats, all elements 8'hFF, i_vec_valid toggling 1/0 between beats, last on beat 4 -> o_sum=-128, o_sum_beats=4.
- Backpressure: result pending with i_sum_ready=0 for 5 cycles -> o_vec_ready=0, o_sum and o_sum_beats stable. i_sum_ready=1 together with i_vec_valid=1 (first beat of next packet) -> both handshakes occur in that cycle, no idle cycle.
- max_beats=4 override, 6 beats of all 1 with last only on beat 6 -> result1 o_sum=128, beats=4, trunc=1; result2 o_sum=64, beats=2, trunc=0.
- Reset asserted during beat 3 of a 5-beat packet, then a 1-beat packet of all 2 -> only one result: o_sum=64, beats=1.
- 9 beats of all 127, acc_width=16:
  - Without VEC_SUM_SAT_EN -> o_sum=-28960 (wrapped 36576).
  - With VEC_SUM_SAT_EN -> o_sum=32767, o_sum_sat=1.
